// File: rtl/parity_frame_receiver_pkg.sv
// Shared definitions for the parity frame receiver: FSM state encoding and line levels.
package parity_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_frame_receiver_if.sv
// Serial-side bundle of the parity frame receiver; master drives the line, slave is the receiver.
interface parity_frame_receiver_if #(
  parameter int DATA_W = 4
);
  import parity_frame_pkg::*;

  // bit_en is a one-cycle strobe: rx is meaningful only in cycles where bit_en=1.
  // data_valid/frame_err are one-cycle result pulses; data_out/parity_err hold between frames.
  logic              bit_en;
  logic              rx;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  state_t            state;

  modport master (
    output bit_en, rx,
    input  data_out, data_valid, parity_err, frame_err, busy, state
  );

  modport slave (
    input  bit_en, rx,
    output data_out, data_valid, parity_err, frame_err, busy, state
  );

endinterface

// File: rtl/parity_frame_receiver_accumulator.sv
// Running 1-bit XOR of a serial bit stream with synchronous clear; shared with the transmitter.
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/parity_frame_receiver.sv
// Strobe-timed serial receiver: start, DATA_W data bits LSB first, parity, stop.
// Rebuilds the word and reports parity mismatch and stop-bit (framing) errors.
module parity_frame_receiver
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  parity_frame_receiver_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mism_q, mism_d;
  logic              dv_q, dv_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              acc_clr, acc_en, acc_out;

  parity_accumulator u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (bus.rx),
    .acc    (acc_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    mism_d  = mism_q;
    perr_d  = perr_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    if (bus.bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = bus.rx;
          end
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          // accumulator already holds the XOR of every data bit at this point
          mism_d  = acc_out ^ bus.rx ^ PARITY_ODD;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (bus.rx == STOP_BIT) begin
            data_d = shift_q;
            perr_d = mism_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mism_q  <= 1'b0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mism_q  <= mism_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Bench for parity_frame_receiver: a 4-bit even-parity and an 8-bit odd-parity instance
// driven with directed and random frames, checked against a frame-level model.
module tb_parity_frame_receiver;
  import parity_frame_pkg::*;

  logic clk;
  logic rst;

  parity_frame_receiver_if #(.DATA_W(4)) b0 ();
  parity_frame_receiver_if #(.DATA_W(8)) b1 ();

  parity_frame_receiver #(.DATA_W(4), .PARITY_ODD(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  parity_frame_receiver #(.DATA_W(8), .PARITY_ODD(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame-level model: expected events are {frame_err, parity_err, data[15:0]}
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [15:0] last_d[2];
  logic        last_p[2];

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic logic odd_of(input int sel);
    return (sel == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? b0.busy : b1.busy;
  endfunction

  function automatic logic [15:0] data_of(input int sel);
    return (sel == 0) ? {12'd0, b0.data_out} : {8'd0, b1.data_out};
  endfunction

  function automatic logic [1:0] state_of(input int sel);
    return (sel == 0) ? b0.state : b1.state;
  endfunction

  task automatic push_event(input int sel, input logic fe);
    logic [17:0] e;
    e = {fe, last_p[sel], last_d[sel]};
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      last_d[s] = '0;
      last_p[s] = 1'b0;
    end
  endtask

  // driver tasks: all drives happen 1 time unit after a rising edge
  task automatic drive(input int sel, input logic en, input logic rxv);
    if (sel == 0) begin
      b0.bit_en = en;
      b0.rx     = rxv;
    end else begin
      b1.bit_en = en;
      b1.rx     = rxv;
    end
  endtask

  task automatic strobe(input int sel, input logic b, input int gap);
    drive(sel, 1'b1, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'($urandom_range(0, 1)));
    repeat (gap) begin
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input int sel, input logic [15:0] d, input logic p,
                            input logic s, input int gmax);
    int dw;
    dw = width_of(sel);
    strobe(sel, START_BIT, $urandom_range(0, gmax));
    chk("busy_in_frame", busy_of(sel), 1);
    for (int i = 0; i < dw; i++) strobe(sel, d[i], $urandom_range(0, gmax));
    strobe(sel, p, $urandom_range(0, gmax));
    if (s) begin
      last_d[sel] = d;
      last_p[sel] = (((^d) ^ odd_of(sel)) != p);
      push_event(sel, 1'b0);
    end else begin
      push_event(sel, 1'b1);
    end
    strobe(sel, s, 0);
    chk("busy_after_stop", busy_of(sel), 0);
  endtask

  // scoreboard monitors, sampled on the falling edge
  logic prev_dv0 = 1'b0, prev_fe0 = 1'b0, prev_dv1 = 1'b0, prev_fe1 = 1'b0;

  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst) begin
      if (prev_dv0) chk("dv_pulse0", b0.data_valid, 0);
      if (prev_fe0) chk("fe_pulse0", b0.frame_err, 0);
      if (b0.data_valid || b0.frame_err) begin
        if (exp_q0.size() == 0) begin
          chk("unexpected_event0", {b0.frame_err, b0.data_valid}, 0);
        end else begin
          e = exp_q0.pop_front();
          chk("kind0", {b0.frame_err, b0.data_valid}, e[17] ? 2'b10 : 2'b01);
          chk("data0", {12'd0, b0.data_out}, e[15:0]);
          chk("perr0", b0.parity_err, e[16]);
        end
      end
    end
    prev_dv0 = b0.data_valid;
    prev_fe0 = b0.frame_err;
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst) begin
      if (prev_dv1) chk("dv_pulse1", b1.data_valid, 0);
      if (prev_fe1) chk("fe_pulse1", b1.frame_err, 0);
      if (b1.data_valid || b1.frame_err) begin
        if (exp_q1.size() == 0) begin
          chk("unexpected_event1", {b1.frame_err, b1.data_valid}, 0);
        end else begin
          e = exp_q1.pop_front();
          chk("kind1", {b1.frame_err, b1.data_valid}, e[17] ? 2'b10 : 2'b01);
          chk("data1", {8'd0, b1.data_out}, e[15:0]);
          chk("perr1", b1.parity_err, e[16]);
        end
      end
    end
    prev_dv1 = b1.data_valid;
    prev_fe1 = b1.frame_err;
  end

  task automatic check_reset_state(input int sel);
    logic [3:0] flags;
    flags = (sel == 0) ? {b0.data_valid, b0.parity_err, b0.frame_err, b0.busy}
                       : {b1.data_valid, b1.parity_err, b1.frame_err, b1.busy};
    chk("reset_flags", flags, 4'b0000);
    chk("reset_data", data_of(sel), 0);
    chk("reset_state", state_of(sel), ST_IDLE);
  endtask

  initial begin
    logic [15:0] d;
    logic        p;
    logic        s;
    int          dw;

    rst = 1'b1;
    drive(0, 1'b0, LINE_IDLE);
    drive(1, 1'b0, LINE_IDLE);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic good frame, bad parity, recovery
    send_frame(0, 16'hB, 1'b1, 1'b1, 0);
    send_frame(0, 16'hB, 1'b0, 1'b1, 1);
    send_frame(0, 16'h3, 1'b0, 1'b1, 1);
    // stop-bit error keeps previous word
    send_frame(0, 16'h5, 1'b0, 1'b0, 1);
    chk("data_held_after_ferr", data_of(0), 16'h3);

    // rx glitches without a strobe are ignored
    repeat (3) begin
      drive(0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    strobe(0, LINE_IDLE, 0);
    chk("glitch_busy", busy_of(0), 0);
    chk("glitch_data", data_of(0), last_d[0]);

    // reset in the middle of a frame
    strobe(0, START_BIT, 0);
    strobe(0, 1'b1, 0);
    strobe(0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_busy", busy_of(0), 0);
    chk("midrst_data", data_of(0), 0);
    chk("midrst_state", state_of(0), ST_IDLE);
    send_frame(0, 16'hA, 1'b0, 1'b1, 1);

    // back-to-back frames, strobes every cycle
    send_frame(0, 16'h0, 1'b0, 1'b1, 0);
    send_frame(0, 16'hF, 1'b0, 1'b1, 0);

    // odd parity, 8-bit instance
    send_frame(1, 16'h81, 1'b1, 1'b1, 1);
    send_frame(1, 16'h81, 1'b0, 1'b1, 1);

    // randomized frames on both instances
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = n % 2;
      dw  = width_of(sel);
      d   = 16'($urandom_range(0, (1 << dw) - 1));
      p   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) strobe(sel, LINE_IDLE, $urandom_range(0, 2));
      send_frame(sel, d, p, s, $urandom_range(0, 3));
    end

    drive(0, 1'b0, LINE_IDLE);
    drive(1, 1'b0, LINE_IDLE);
    repeat (5) @(posedge clk);
    #1;
    chk("pending_events0", exp_q0.size(), 0);
    chk("pending_events1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
